serial_subtractor: RTL

Bit-serial two's-complement subtractor: computes `in1 - in2 - b_in` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the adder datapath and is used where area matters more than latency. A start/busy/done handshake controls it. Operands are captured at start, and results are held stable until the next accepted start.

---
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial two's-complement subtractor. Computes
//                in1 - in2 - b_in one bit per clock, LSB first, with a single
//                full-subtractor cell and a borrow flip-flop, under a
//                start/busy/done handshake.
//                Optional signed-overflow output enabled by defining
//                SERIAL_SUB_OVF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic               w_br_nxt;

    // Full-subtractor cell operating on the current LSBs and stored borrow.
    always_comb begin
        w_a      = r_a_sr[0];
        w_b      = r_b_sr[0];
        w_d      = w_a ^ w_b ^ r_borrow;
        w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
        w_accept = (r_state == S_IDLE) && start;
        w_step   = (r_state == S_SHIFT);
        w_last   = w_step && (r_cnt == c_LAST);
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs (busy/done decode directly from state).
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one bit-step per SHIFT cycle; results
    // are only touched on accept and during SHIFT, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= in1;
            r_b_sr   <= in2;
            r_borrow <= b_in;
            r_cnt    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
        end else if (w_step) begin
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_borrow <= w_br_nxt;
            r_cnt    <= r_cnt + c_ONE;
            diff     <= {w_d, diff[WIDTH-1:1]};
            if (w_last) begin
                b_out <= w_br_nxt;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: operand signs differ and result sign differs from in1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (w_accept) begin
            ovf <= 1'b0;
        end else if (w_last) begin
            ovf <= (w_a != w_b) && (w_d != w_a);
        end
    end
`endif

endmodule

`default_nettype wire
